// File: rtl/dds_timed_param_sequencer_if.sv
// Command channel of the DDS parameter sequencer: one timed frequency/phase update per
// valid & ready handshake.
interface dds_timed_param_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [47:0] cmd_time;
    logic [47:0] cmd_freq;
    logic [13:0] cmd_phase;
    logic        cmd_cont;

    modport master (
        output cmd_valid, cmd_time, cmd_freq, cmd_phase, cmd_cont,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_time, cmd_freq, cmd_phase, cmd_cont,
        output cmd_ready
    );
endinterface

// File: rtl/dds_timed_param_sequencer.sv
// Timed parameter sequencer for the DDS phase MAC: queues commands and applies each one when
// timestamp reaches its cmd_time. Define DDS_SEQ_FLUSH_EN to add the `flush` input.
module dds_timed_param_sequencer #(
    parameter int FIFO_DEPTH = 16,
    parameter int MUL_CHUNK  = 16
) (
    input  logic                              clk,
    input  logic                              reset,
`ifdef DDS_SEQ_FLUSH_EN
    input  logic                              flush,
`endif
    input  logic [47:0]                       timestamp,
    dds_timed_param_sequencer_if.slave        cmd,
    input  logic                              late_clr,
    output logic [47:0]                       time_offset,
    output logic [47:0]                       freq,
    output logic [13:0]                       phase,
    output logic [47:0]                       acc_phase,
    output logic                              param_update,
    output logic                              busy,
    output logic                              late_error
);
    localparam int TW         = 48;
    localparam int PW         = 14;
    localparam int MUL_CYCLES = TW / MUL_CHUNK;
    localparam int AW         = $clog2(FIFO_DEPTH);
    localparam int CW         = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    typedef struct packed {
        logic [TW-1:0] t;
        logic [TW-1:0] f;
        logic [PW-1:0] p;
        logic          c;
    } cmd_t;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CALC, S_ARMED, S_APPLY} state_t;

    state_t               state_q, state_d;
    cmd_t                 mem_q [FIFO_DEPTH];
    cmd_t                 cmd_in, stg_q;
    logic [AW:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                 ready_q, ready_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 late_q, late_d;
    logic [TW-1:0]        off_q, freq_q, acc_q;
    logic [PW-1:0]        phase_q;
    logic [TW-1:0]        dt_sh_q, fsh_q, prod_q, part, new_acc;
    logic signed [TW-1:0] d;
    logic                 flush_w, push, pop, apply, late_set, empty;

`ifdef DDS_SEQ_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    assign cmd_in         = {cmd.cmd_time, cmd.cmd_freq, cmd.cmd_phase, cmd.cmd_cont};
    assign empty          = (wr_ptr_q == rd_ptr_q);
    assign push           = cmd.cmd_valid & ready_q & ~flush_w;
    assign cmd.cmd_ready  = ready_q & ~flush_w;
    assign d              = $signed(timestamp - stg_q.t);
    // One MUL_CHUNK slice of dt times the pre-shifted old frequency; carries past bit 47 are dropped.
    assign part           = TW'(dt_sh_q[MUL_CHUNK-1:0]) * fsh_q;
    assign new_acc        = stg_q.c ? (acc_q + prod_q + {phase_q, {(TW-PW){1'b0}}}) : '0;

    assign time_offset    = off_q;
    assign freq           = freq_q;
    assign phase          = phase_q;
    assign acc_phase      = acc_q;
    assign late_error     = late_q;
    assign param_update   = (state_q == S_APPLY);
    assign busy           = !empty || (state_q != S_IDLE);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pop      = 1'b0;
        apply    = 1'b0;
        late_set = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                cnt_d   = '0;
                state_d = S_CALC;
            end
            S_CALC: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(MUL_CYCLES - 1)) state_d = S_ARMED;
            end
            S_ARMED: begin
                // d == -1 lands the new values exactly in the cycle where timestamp == cmd_time.
                if (d >= 48'sd0) begin
                    late_set = 1'b1;
                    apply    = 1'b1;
                    state_d  = S_APPLY;
                end else if (d == -48'sd1) begin
                    apply   = 1'b1;
                    state_d = S_APPLY;
                end
            end
            S_APPLY: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (flush_w) begin
            state_d  = S_IDLE;
            pop      = 1'b0;
            apply    = 1'b0;
            late_set = 1'b0;
        end
    end

    always_comb begin
        wr_ptr_d = flush_w ? '0 : wr_ptr_q + (AW+1)'(push);
        rd_ptr_d = flush_w ? '0 : rd_ptr_q + (AW+1)'(pop);
        ready_d  = ((wr_ptr_d - rd_ptr_d) != (AW+1)'(FIFO_DEPTH));
        late_d   = late_set ? 1'b1 : (late_clr ? 1'b0 : late_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ready_q  <= 1'b0;
            cnt_q    <= '0;
            late_q   <= 1'b0;
            off_q    <= '0;
            freq_q   <= '0;
            phase_q  <= '0;
            acc_q    <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ready_q  <= ready_d;
            cnt_q    <= cnt_d;
            late_q   <= late_d;
            if (apply) begin
                off_q   <= stg_q.t;
                freq_q  <= stg_q.f;
                phase_q <= stg_q.p;
                acc_q   <= new_acc;
            end
        end
    end

    // Datapath storage: FIFO array, staging copy of the head and the shift-add multiplier.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= cmd_in;
        if (pop)  stg_q <= mem_q[rd_ptr_q[AW-1:0]];
        if (state_q == S_LOAD) begin
            dt_sh_q <= stg_q.t - off_q;
            fsh_q   <= freq_q;
            prod_q  <= '0;
        end else if (state_q == S_CALC) begin
            dt_sh_q <= dt_sh_q >> MUL_CHUNK;
            fsh_q   <= fsh_q << MUL_CHUNK;
            prod_q  <= prod_q + part;
        end
    end
endmodule

// File: tb/tb_dds_timed_param_sequencer.sv
// Bench for dds_timed_param_sequencer: directed vector table, multi-cycle corner sequences and
// random command streams checked against an arithmetic reference model.
`timescale 1ns/1ps
module tb_dds_timed_param_sequencer;
    logic        clk = 1'b0;
    logic        reset;
    logic [47:0] ts;
    logic        ts_set_en;
    logic [47:0] ts_set_val;
    logic        late_clr;
    logic [47:0] time_offset, freq, acc_phase;
    logic [13:0] phase;
    logic        param_update, busy, late_error;
`ifdef DDS_SEQ_FLUSH_EN
    logic        flush;
`endif

    dds_timed_param_sequencer_if cmd_if ();

    dds_timed_param_sequencer dut (
        .clk          (clk),
        .reset        (reset),
`ifdef DDS_SEQ_FLUSH_EN
        .flush        (flush),
`endif
        .timestamp    (ts),
        .cmd          (cmd_if),
        .late_clr     (late_clr),
        .time_offset  (time_offset),
        .freq         (freq),
        .phase        (phase),
        .acc_phase    (acc_phase),
        .param_update (param_update),
        .busy         (busy),
        .late_error   (late_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ts <= ts_set_en ? ts_set_val : ts + 48'd1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [47:0] t;
        logic [47:0] f;
        logic [13:0] p;
        logic [47:0] acc;
        bit          late;
    } exp_t;

    exp_t        expq[$];
    exp_t        mon_e;
    logic [47:0] m_off, m_freq, m_acc;
    logic [13:0] m_phase;

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (ts=%h)", name, act, exp, ts);
        end
    endtask

    // Reference: commands take effect in order; each new acc is computed from the previous set.
    function automatic void model_add(input logic [47:0] t, input logic [47:0] f,
                                      input logic [13:0] p, input logic c, input bit late);
        exp_t e;
        logic [47:0] dt, acc;
        dt  = t - m_off;
        acc = c ? (m_acc + dt * m_freq + ({34'd0, m_phase} << 34)) : 48'd0;
        e.t = t; e.f = f; e.p = p; e.acc = acc; e.late = late;
        expq.push_back(e);
        m_off = t; m_freq = f; m_phase = p; m_acc = acc;
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            if (param_update) begin
                if (expq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_update: got update at ts=%h required none", ts);
                end else begin
                    mon_e = expq.pop_front();
                    if (!mon_e.late) chk("apply_ts", ts, mon_e.t);
                    chk("apply_offset", time_offset, mon_e.t);
                    chk("apply_freq", freq, mon_e.f);
                    chk("apply_phase", {34'd0, phase}, {34'd0, mon_e.p});
                    chk("apply_acc", acc_phase, mon_e.acc);
                end
            end else if (expq.size() != 0 && !expq[0].late && ts == expq[0].t) begin
                checks++; errors++;
                $display("FAIL missed_update: got no update at ts=%h required one", ts);
            end
        end
    end

    task automatic push(input logic [47:0] t, input logic [47:0] f, input logic [13:0] p,
                        input logic c, input bit late);
        int n = 0;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_time  = t;
        cmd_if.cmd_freq  = f;
        cmd_if.cmd_phase = p;
        cmd_if.cmd_cont  = c;
        while (!cmd_if.cmd_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_if.cmd_ready) begin
            checks++; errors++;
            $display("FAIL push_timeout: got ready=0 for %0d cycles required 1", n);
            cmd_if.cmd_valid = 1'b0;
        end else begin
            model_add(t, f, p, c, late);
            @(posedge clk);
            #1 cmd_if.cmd_valid = 1'b0;
        end
    endtask

    task automatic wait_ts(input logic [47:0] target);
        int n = 0;
        while (ts !== target && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (ts !== target) begin
            checks++; errors++;
            $display("FAIL wait_ts: got ts=%h required %h", ts, target);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (expq.size() != 0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 48'(expq.size()), 48'd0);
    endtask

    task automatic set_ts(input logic [47:0] v);
        @(negedge clk);
        ts_set_en  = 1'b1;
        ts_set_val = v;
        @(negedge clk);
        ts_set_en  = 1'b0;
    endtask

    typedef struct {
        logic [47:0] t;
        logic [47:0] f;
        logic [13:0] p;
        logic        c;
        logic [47:0] acc;
    } vec_t;

    vec_t        tbl[5];
    logic [47:0] prev_f, base, t_r;
    logic [47:0] s_off, s_freq, s_acc;
    logic [13:0] s_phase;

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish by %0t required earlier", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{t: 48'd100,  f: 48'h10, p: 14'd0, c: 1'b0, acc: 48'h0};
        tbl[1] = '{t: 48'd1100, f: 48'h20, p: 14'd0, c: 1'b1, acc: 48'h3E80};
        tbl[2] = '{t: 48'd1200, f: 48'h20, p: 14'd3, c: 1'b1, acc: 48'h4B00};
        tbl[3] = '{t: 48'd1300, f: 48'h5,  p: 14'd7, c: 1'b1, acc: 48'hC_0000_5780};
        tbl[4] = '{t: 48'd1400, f: 48'h1,  p: 14'd0, c: 1'b0, acc: 48'h0};

        reset = 1'b1; late_clr = 1'b0; ts_set_en = 1'b1; ts_set_val = 48'd0;
        cmd_if.cmd_valid = 1'b0; cmd_if.cmd_time = '0; cmd_if.cmd_freq = '0;
        cmd_if.cmd_phase = '0; cmd_if.cmd_cont = 1'b0;
`ifdef DDS_SEQ_FLUSH_EN
        flush = 1'b0;
`endif
        m_off = '0; m_freq = '0; m_acc = '0; m_phase = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {47'd0, cmd_if.cmd_ready}, 48'd0);
        chk("rst_offset", time_offset, 48'd0);
        chk("rst_freq", freq, 48'd0);
        chk("rst_acc", acc_phase, 48'd0);
        chk("rst_phase", {34'd0, phase}, 48'd0);
        chk("rst_update", {47'd0, param_update}, 48'd0);
        chk("rst_busy", {47'd0, busy}, 48'd0);
        chk("rst_late", {47'd0, late_error}, 48'd0);
        reset = 1'b0; ts_set_en = 1'b0;

        // Directed table: on-time application, phase-continuous accumulation.
        wait_ts(48'd10);
        prev_f = 48'd0;
        for (int i = 0; i < 5; i++) begin
            push(tbl[i].t, tbl[i].f, tbl[i].p, tbl[i].c, 1'b0);
            wait_ts(tbl[i].t - 48'd1);
            chk("pre_update", {47'd0, param_update}, 48'd0);
            chk("pre_freq", freq, prev_f);
            @(negedge clk);
            chk("tbl_update", {47'd0, param_update}, 48'd1);
            chk("tbl_offset", time_offset, tbl[i].t);
            chk("tbl_freq", freq, tbl[i].f);
            chk("tbl_phase", {34'd0, phase}, {34'd0, tbl[i].p});
            chk("tbl_acc", acc_phase, tbl[i].acc);
            chk("tbl_late", {47'd0, late_error}, 48'd0);
            prev_f = tbl[i].f;
        end

        // Late command, then clear.
        push(48'd50, 48'd7, 14'd0, 1'b1, 1'b1);
        repeat (12) @(negedge clk);
        chk("late_set", {47'd0, late_error}, 48'd1);
        chk("late_applied", 48'(expq.size()), 48'd0);
        chk("late_freq", freq, 48'd7);
        late_clr = 1'b1;
        @(negedge clk);
        late_clr = 1'b0;
        chk("late_clr", {47'd0, late_error}, 48'd0);

        // Fill: one command sits in staging, sixteen more fill the FIFO.
        base = ts + 48'd300;
        for (int i = 0; i < 17; i++)
            push(base + 48'(10 * i), {16'($urandom), 32'($urandom)}, 14'($urandom),
                 1'($urandom), 1'b0);
        chk("fill_ready_low", {47'd0, cmd_if.cmd_ready}, 48'd0);
        chk("fill_busy", {47'd0, busy}, 48'd1);
        wait_ts(base + 48'd3);
        chk("fill_ready_again", {47'd0, cmd_if.cmd_ready}, 48'd1);
        wait_drain();
        chk("fill_late", {47'd0, late_error}, 48'd0);

        // Timestamp wrap between applied offset and next command.
        set_ts(48'hFFFF_FFFF_FF00);
        push(48'hFFFF_FFFF_FFF0, 48'd1, 14'd0, 1'b0, 1'b0);
        push(48'h10, 48'd1, 14'd0, 1'b1, 1'b0);
        wait_ts(48'h10);
        chk("wrap_acc", acc_phase, 48'h20);
        chk("wrap_offset", time_offset, 48'h10);
        chk("wrap_update", {47'd0, param_update}, 48'd1);
        chk("wrap_late", {47'd0, late_error}, 48'd0);

        // Random stream against the model.
        t_r = ts + 48'd30;
        for (int i = 0; i < 24; i++) begin
            push(t_r, {16'($urandom), 32'($urandom)}, 14'($urandom), 1'($urandom), 1'b0);
            t_r = t_r + 48'd8 + 48'($urandom_range(0, 30));
        end
        wait_drain();
        chk("rand_late", {47'd0, late_error}, 48'd0);
        @(negedge clk);
        chk("rand_busy", {47'd0, busy}, 48'd0);

`ifdef DDS_SEQ_FLUSH_EN
        // Flush while armed: outputs hold, nothing applied.
        s_off = m_off; s_freq = m_freq; s_acc = m_acc; s_phase = m_phase;
        push(ts + 48'd100, 48'd3, 14'd1, 1'b1, 1'b0);
        repeat (20) @(negedge clk);
        flush = 1'b1;
        expq.delete();
        m_off = s_off; m_freq = s_freq; m_acc = s_acc; m_phase = s_phase;
        #1 chk("flush_ready", {47'd0, cmd_if.cmd_ready}, 48'd0);
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", {47'd0, busy}, 48'd0);
        chk("flush_freq_hold", freq, s_freq);
        chk("flush_acc_hold", acc_phase, s_acc);
        repeat (120) @(negedge clk);
`endif

        // Reset while armed: queued command discarded, outputs cleared.
        push(ts + 48'd100, 48'd5, 14'd9, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        reset = 1'b1;
        expq.delete();
        m_off = '0; m_freq = '0; m_acc = '0; m_phase = '0;
        @(negedge clk);
        chk("rst2_ready", {47'd0, cmd_if.cmd_ready}, 48'd0);
        reset = 1'b0;
        chk("rst2_freq", freq, 48'd0);
        chk("rst2_offset", time_offset, 48'd0);
        chk("rst2_acc", acc_phase, 48'd0);
        chk("rst2_phase", {34'd0, phase}, 48'd0);
        @(negedge clk);
        chk("rst2_busy", {47'd0, busy}, 48'd0);
        chk("rst2_ready_back", {47'd0, cmd_if.cmd_ready}, 48'd1);
        repeat (120) @(negedge clk);

        // Recovery after reset.
        push(ts + 48'd40, 48'h10, 14'd2, 1'b1, 1'b0);
        wait_drain();
        @(negedge clk);
        chk("end_busy", {47'd0, busy}, 48'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
